alu_op_sequencer: RTL and testbench

- Command-driven controller that sequences the 4-bit ALU operations (logic, add, multiply, divide, shift) behind a valid/ready command port and a valid/ready response port.
- Single-cycle ops complete in one cycle. Multiply runs as an iterative shift-add and divide as an iterative restoring divide, each over WIDTH cycles.
- Sits between a host or test driver and the ALU datapath, and owns operand latching, iteration control and result holding.

---
 rtl/alu_op_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command-driven sequencer for a small ALU. It accepts one command at a
//   time and returns one response for each command. Logic, add and shift
//   commands finish in one cycle. Multiply runs as a shift-add and divide
//   as a restoring divide, one bit per cycle over WIDTH cycles.
//
//   Handshake: both ports use valid/ready. A transfer happens on a rising
//   edge where valid && ready is true. The command side keeps its fields
//   stable while cmd_valid is high and cmd_ready is low. The sequencer keeps
//   rsp_result, rsp_zero and rsp_err stable while rsp_valid is high and
//   rsp_ready is low.
//
//   Optional feature: define ALU_SEQ_EARLY_EXIT_EN to let some commands
//   skip the iterative states and finish in one cycle:
//     - multiply when either operand is zero;
//     - divide when the dividend is smaller than a nonzero divisor.
//   The results are the same in both builds. Only the latency changes.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   cmd_valid    command present                  (in)
//   cmd_ready    sequencer idle, can accept        (out)
//   cmd_op       0 AND 1 OR 2 NAND 3 XOR 4 ADD 5 MUL 6 DIV 7 SHIFT, others illegal
//   cmd_a        operand A, also dividend and shift source
//   cmd_b        operand B, also divisor
//   cmd_cin      carry-in for ADD
//   cmd_amt      shift amount
//   cmd_dir      shift direction: 0 left, 1 right; logical shift, zero fill
//   rsp_valid    response available               (out)
//   rsp_ready    consumer takes the response       (in)
//   rsp_result   packed 2*WIDTH result
//   rsp_zero     rsp_result == 0
//   rsp_err      illegal opcode or divide by zero
//   dbg_state    current FSM state: 0 IDLE, 1 MUL_IT, 2 DIV_IT, 3 DONE

module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int SAW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic                 cmd_cin,
  input  logic [SAW-1:0]       cmd_amt,
  input  logic                 cmd_dir,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic [1:0]           dbg_state
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NAND  = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_SHIFT = 4'd7;

  // The counter value of the last iteration. That iteration also loads
  // the response registers, so the response appears WIDTH cycles after
  // a single-cycle command would.
  localparam logic [SAW-1:0] LAST_IT = SAW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_IT = 2'd1,
    DIV_IT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [SAW-1:0]       cnt;
  logic [WIDTH-1:0]     a_q;      // dividend, which shifts into the quotient
  logic [WIDTH-1:0]     b_q;      // multiplier (shifts right) or divisor
  logic [2*WIDTH-1:0]   acc_q;    // product accumulator
  logic [2*WIDTH-1:0]   mcand_q;  // multiplicand, shifts left
  logic [WIDTH-1:0]     rem_q;    // partial remainder
  logic [2*WIDTH-1:0]   res_q;
  logic                 zero_q;
  logic                 err_q;

  logic                 cmd_accept;
  logic [2*WIDTH-1:0]   fast_res;
  logic                 fast_err;
  logic                 fast_done;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     shift_y;
  logic [2*WIDTH-1:0]   mul_acc_nx;
  logic [WIDTH:0]       div_tmp;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem_nx;
  logic [WIDTH-1:0]     div_quo_nx;

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state;
  assign cmd_accept = cmd_valid && cmd_ready;

  // Compute the one-cycle result straight from the command fields.
  // fast_done is low only for multiply and divide commands that must run
  // the iterative states.
  always_comb begin
    fast_res  = '0;
    fast_err  = 1'b0;
    fast_done = 1'b1;
    add_sum   = {1'b0, cmd_a} + {1'b0, cmd_b} + {{WIDTH{1'b0}}, cmd_cin};
    shift_y   = cmd_dir ? (cmd_a >> cmd_amt) : (cmd_a << cmd_amt);
    case (cmd_op)
      OP_AND:   fast_res = {{WIDTH{1'b0}}, cmd_a & cmd_b};
      OP_OR:    fast_res = {{WIDTH{1'b0}}, cmd_a | cmd_b};
      OP_NAND:  fast_res = {{WIDTH{1'b0}}, ~(cmd_a & cmd_b)};
      OP_XOR:   fast_res = {{WIDTH{1'b0}}, cmd_a ^ cmd_b};
      OP_ADD:   fast_res = {{(WIDTH-1){1'b0}}, add_sum};
      OP_SHIFT: fast_res = {{WIDTH{1'b0}}, shift_y};
      OP_MUL: begin
`ifdef ALU_SEQ_EARLY_EXIT_EN
        if (cmd_a == '0 || cmd_b == '0) fast_res = '0;
        else                            fast_done = 1'b0;
`else
        fast_done = 1'b0;
`endif
      end
      OP_DIV: begin
        if (cmd_b == '0) begin
          // Divide by zero: the quotient is all ones and the remainder is A.
          fast_res = {cmd_a, {WIDTH{1'b1}}};
          fast_err = 1'b1;
        end else begin
`ifdef ALU_SEQ_EARLY_EXIT_EN
          if (cmd_a < cmd_b) fast_res = {cmd_a, {WIDTH{1'b0}}};
          else               fast_done = 1'b0;
`else
          fast_done = 1'b0;
`endif
        end
      end
      default:  fast_err = 1'b1;
    endcase
  end

  // One step of each iterative algorithm, computed from the current registers.
  always_comb begin
    mul_acc_nx = acc_q + (b_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    div_tmp    = {rem_q, a_q[WIDTH-1]};
    div_diff   = div_tmp - {1'b0, b_q};
    div_ge     = (div_tmp >= {1'b0, b_q});
    div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
    div_quo_nx = {a_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          if (fast_done)             state_nx = DONE;
          else if (cmd_op == OP_MUL) state_nx = MUL_IT;
          else                       state_nx = DIV_IT;
        end
      end
      MUL_IT, DIV_IT: begin
        if (cnt == LAST_IT) state_nx = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            cnt     <= '0;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, cmd_a};
            rem_q   <= '0;
            res_q   <= fast_res;
            zero_q  <= (fast_res == '0);
            err_q   <= fast_err;
          end
        end
        MUL_IT: begin
          acc_q   <= mul_acc_nx;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_IT) begin
            res_q  <= mul_acc_nx;
            zero_q <= (mul_acc_nx == '0);
            err_q  <= 1'b0;
          end
        end
        DIV_IT: begin
          a_q   <= div_quo_nx;
          rem_q <= div_rem_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_IT) begin
            res_q  <= {div_rem_nx, div_quo_nx};
            zero_q <= ({div_rem_nx, div_quo_nx} == '0);
            err_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer (WIDTH=4). Each test task
//   drives commands and pushes the expected {err, zero, result} word onto
//   exp_q. The collect task pops that word when the response appears and
//   compares it with the DUT output. It also checks the latency, that the
//   response stays stable while held, and that the handshake releases.

module tb_alu_op_sequencer;

  localparam int W   = 4;
  localparam int SAW = 2;
  localparam int EW  = 2*W + 2;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic             cmd_cin;
  logic [SAW-1:0]   cmd_amt;
  logic             cmd_dir;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic [1:0]       dbg_state;

  logic [EW-1:0]    exp_q[$];
  int               checks;
  int               errors;
  int               cyc;
  int               accept_cyc;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_cin    (cmd_cin),
    .cmd_amt    (cmd_amt),
    .cmd_dir    (cmd_dir),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model returning {err, zero, result}.
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin,
                                          input logic [SAW-1:0] amt, input logic dir);
    logic [2*W-1:0] r;
    logic [W-1:0]   s;
    logic           e;
    r = '0;
    e = 1'b0;
    case (op)
      4'd0: r = {{W{1'b0}}, a & b};
      4'd1: r = {{W{1'b0}}, a | b};
      4'd2: r = {{W{1'b0}}, ~(a & b)};
      4'd3: r = {{W{1'b0}}, a ^ b};
      4'd4: r = (2*W)'(a) + (2*W)'(b) + (2*W)'(cin);
      4'd5: r = (2*W)'(a) * (2*W)'(b);
      4'd6: begin
        if (b == '0) begin
          r = {a, {W{1'b1}}};
          e = 1'b1;
        end else begin
          r = {a % b, a / b};
        end
      end
      4'd7: begin
        s = dir ? (a >> amt) : (a << amt);
        r = {{W{1'b0}}, s};
      end
      default: e = 1'b1;
    endcase
    return {e, (r == '0), r};
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    int lat;
    lat = 1;
    if (op == 4'd5) lat = W + 1;
    if (op == 4'd6 && b != '0) lat = W + 1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (op == 4'd5 && (a == '0 || b == '0)) lat = 1;
    if (op == 4'd6 && b != '0 && a < b) lat = 1;
`endif
    return lat;
  endfunction

  // Driver: present a command and hold it until it is accepted. The task
  // returns 1 time unit after the accept edge.
  task automatic drive_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [SAW-1:0] amt, input logic dir,
                           input logic [EW-1:0] exp, input bit push);
    int n;
    @(negedge clk);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_amt   = amt;
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for op %0d", op);
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
  endtask

  // Wait for the response, then check its latency, its value, its
  // stability while held, and the release. Called right after drive_cmd.
  task automatic collect(input int exp_lat, input int hold);
    int lat;
    logic [EW-1:0] exp, got;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready: cmd_ready=%b required 0 at latency %0d", cmd_ready, lat);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry for response");
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles", lat);
      return;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d required %0d", lat, exp_lat);
    end
    got = {rsp_err, rsp_zero, rsp_result};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL result: err/zero/result got %b/%b/%h required %b/%b/%h",
               got[EW-1], got[EW-2], got[2*W-1:0], exp[EW-1], exp[EW-2], exp[2*W-1:0]);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || {rsp_err, rsp_zero, rsp_result} !== exp) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b ready=%b result=%h required valid=1 ready=0 result=%h",
                 i, rsp_valid, cmd_ready, rsp_result, exp[2*W-1:0]);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 8'h00 ||
        rsp_zero !== 1'b0 || rsp_err !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h zero=%b err=%b state=%0d required 1/0/00/0/0/0",
               cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, dbg_state);
    end
  endtask

  task automatic test_logic();
    drive_cmd(4'd0, 4'b1010, 4'b1100, 1'b0, 2'd0, 1'b0, {2'b00, 8'h08}, 1'b1);
    collect(1, 0);
    drive_cmd(4'd3, 4'b1010, 4'b1100, 1'b0, 2'd0, 1'b0, {2'b00, 8'h06}, 1'b1);
    collect(1, 0);
    drive_cmd(4'd2, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b0, {2'b01, 8'h00}, 1'b1);
    collect(1, 0);
  endtask

  task automatic test_add();
    drive_cmd(4'd4, 4'b0110, 4'b0011, 1'b1, 2'd0, 1'b0, {2'b00, 8'h0A}, 1'b1);
    collect(1, 0);
    drive_cmd(4'd4, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b0, {2'b00, 8'h10}, 1'b1);
    collect(1, 0);
  endtask

  task automatic test_mul_div();
    drive_cmd(4'd5, 4'b1001, 4'b0010, 1'b0, 2'd0, 1'b0, {2'b00, 8'h12}, 1'b1);
    collect(W + 1, 0);
    drive_cmd(4'd5, 4'b1111, 4'b1111, 1'b0, 2'd0, 1'b0, {2'b00, 8'hE1}, 1'b1);
    collect(W + 1, 0);
    drive_cmd(4'd6, 4'b1010, 4'b0010, 1'b0, 2'd0, 1'b0, {2'b00, 8'h05}, 1'b1);
    collect(W + 1, 0);
    drive_cmd(4'd6, 4'b1101, 4'b0011, 1'b0, 2'd0, 1'b0, {2'b00, 8'h14}, 1'b1);
    collect(W + 1, 0);
    drive_cmd(4'd6, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0, {2'b10, 8'hAF}, 1'b1);
    collect(1, 0);
  endtask

  // These commands take the early exit when the feature is built in.
  task automatic test_early_exit_cases();
    drive_cmd(4'd5, 4'b0000, 4'b0111, 1'b0, 2'd0, 1'b0, {2'b01, 8'h00}, 1'b1);
    collect(exp_latency(4'd5, 4'b0000, 4'b0111), 0);
    drive_cmd(4'd6, 4'b0011, 4'b1001, 1'b0, 2'd0, 1'b0, {2'b00, 8'h30}, 1'b1);
    collect(exp_latency(4'd6, 4'b0011, 4'b1001), 0);
  endtask

  task automatic test_shift();
    drive_cmd(4'd7, 4'b1010, 4'b0000, 1'b0, 2'd1, 1'b0, {2'b00, 8'h04}, 1'b1);
    collect(1, 3);
    drive_cmd(4'd7, 4'b1010, 4'b0000, 1'b0, 2'd2, 1'b1, {2'b00, 8'h02}, 1'b1);
    collect(1, 0);
    drive_cmd(4'd7, 4'b1011, 4'b0000, 1'b0, 2'd0, 1'b1, {2'b00, 8'h0B}, 1'b1);
    collect(1, 0);
  endtask

  task automatic test_reset_mid_op();
    drive_cmd(4'd5, 4'b1001, 4'b0010, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_op: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_op_after: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
    drive_cmd(4'hC, 4'b1010, 4'b0101, 1'b0, 2'd0, 1'b0, {2'b11, 8'h00}, 1'b1);
    collect(1, 0);
  endtask

  task automatic test_back_to_back();
    int prev;
    drive_cmd(4'd1, 4'b0101, 4'b0010, 1'b0, 2'd0, 1'b0, {2'b00, 8'h07}, 1'b1);
    prev = accept_cyc;
    collect(1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cmd(4'd4, 4'(i), 4'(i + 5), 1'b0, 2'd0, 1'b0, {2'b00, 8'(2*i + 5)}, 1'b1);
      checks++;
      if (accept_cyc - prev != 2) begin
        errors++;
        $display("FAIL b2b_spacing: accept spacing %0d required 2", accept_cyc - prev);
      end
      prev = accept_cyc;
      collect(1, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [3:0]     op;
      logic [W-1:0]   a, b;
      logic           cin, dir;
      logic [SAW-1:0] amt;
      op  = 4'($urandom_range(0, 15));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      amt = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      drive_cmd(op, a, b, cin, amt, dir, model(op, a, b, cin, amt, dir), 1'b1);
      collect(exp_latency(op, a, b), $urandom_range(0, 2));
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    accept_cyc = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_cin    = 1'b0;
    cmd_amt    = '0;
    cmd_dir    = 1'b0;
    rsp_ready  = 1'b0;

    test_reset();
    test_logic();
    test_add();
    test_mul_div();
    test_early_exit_cases();
    test_shift();
    test_reset_mid_op();
    test_back_to_back();
    test_random();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
